// File: rtl/stream_compressor_if.sv
// AXI4-Stream input and flattened output bundle for stream_compressor.
// slave = compressor side, master = source/sink side.
interface stream_compressor_if #(
   parameter int TDATA_BYTES = 8,
   parameter int TKEEP_WIDTH = TDATA_BYTES,
   parameter int TID_WIDTH   = 4,
   parameter int TDEST_WIDTH = 1
);
   logic                     target_tvalid;
   logic                     target_tready;
   logic [8*TDATA_BYTES-1:0] target_tdata;
   logic [TKEEP_WIDTH-1:0]   target_tkeep;
   logic [TID_WIDTH-1:0]     target_tid;
   logic [TDEST_WIDTH-1:0]   target_tdest;
   logic                     target_tlast;
   logic                     initiator_tvalid;
   logic                     initiator_tready;
   logic [8*TDATA_BYTES-1:0] initiator_tdata;

   modport slave (
      input  target_tvalid, target_tdata, target_tkeep, target_tid, target_tdest,
             target_tlast, initiator_tready,
      output target_tready, initiator_tvalid, initiator_tdata
   );

   modport master (
      output target_tvalid, target_tdata, target_tkeep, target_tid, target_tdest,
             target_tlast, initiator_tready,
      input  target_tready, initiator_tvalid, initiator_tdata
   );
endinterface

// File: rtl/stream_compressor.sv
// Store-and-forward AXI4-Stream flattener: each segment becomes a header word plus raw data words.
// Optional STREAM_COMPRESSOR_PINGPONG_EN adds a second buffer so filling overlaps draining.
module stream_compressor #(
   parameter int TDATA_BYTES = 8,
   parameter int TKEEP_WIDTH = TDATA_BYTES,
   parameter int TID_WIDTH   = 4,
   parameter int TDEST_WIDTH = 1,
   parameter int MAX_BEATS   = 256
) (
   input  logic              aclk,
   input  logic              aresetn,
   stream_compressor_if.slave bus
);
   localparam int DW = 8 * TDATA_BYTES;
`ifdef STREAM_COMPRESSOR_PINGPONG_EN
   localparam int NBUF = 2;
`else
   localparam int NBUF = 1;
`endif
   localparam int AW = $clog2(NBUF * MAX_BEATS);

   typedef enum logic [1:0] {FILL, HEADER, DRAIN} state_t;
   state_t state, state_nxt;

   logic [DW-1:0]          mem [NBUF*MAX_BEATS];
   logic [DW-1:0]          hdr_buf [2];
   logic [DW-1:0]          out_data;
   logic [7:0]             wr_ptr;
   logic [8:0]             rd_ptr;
   logic [7:0]             cur_beats;
   logic                   wr_sel, rd_sel;
   logic [1:0]             nfull;
   logic                   armed;
   logic [TID_WIDTH-1:0]   seg_tid;
   logic [TDEST_WIDTH-1:0] seg_tdest;

   logic          in_hs, out_hs, close_now, first_beat;
   logic          load_hdr, load_word, drain_done;
   logic [DW-1:0] live_hdr, next_hdr;
   logic [AW-1:0] wr_addr, rd_addr;

   function automatic logic [7:0] keep_msb(input logic [TKEEP_WIDTH-1:0] keep);
      keep_msb = '0;
      for (int i = 0; i < TKEEP_WIDTH; i++)
         if (keep[i]) keep_msb = 8'(i);
   endfunction

   function automatic logic [DW-1:0] make_hdr(input logic [TID_WIDTH-1:0]   tid,
                                              input logic [TDEST_WIDTH-1:0] tdest,
                                              input logic [7:0]             beats,
                                              input logic [7:0]             kcnt);
      make_hdr = '0;
      make_hdr[TID_WIDTH-1:0]     = tid;
      make_hdr[8 +: TDEST_WIDTH]  = tdest;
      make_hdr[23:16]             = beats;
      make_hdr[31:24]             = kcnt;
   endfunction

   assign in_hs      = bus.target_tvalid && bus.target_tready;
   assign out_hs     = bus.initiator_tvalid && bus.initiator_tready;
   assign first_beat = (wr_ptr == 8'd0);
   assign close_now  = in_hs && (bus.target_tlast || wr_ptr == 8'(MAX_BEATS - 1));

   // A segment closed without tlast is a full-width continuation chunk.
   assign live_hdr = make_hdr(first_beat ? bus.target_tid   : seg_tid,
                              first_beat ? bus.target_tdest : seg_tdest,
                              wr_ptr,
                              bus.target_tlast ? keep_msb(bus.target_tkeep) : 8'(TDATA_BYTES - 1));
   // An already-closed buffer is older than one closing this cycle.
   assign next_hdr = (nfull != 2'd0) ? hdr_buf[rd_sel] : live_hdr;

   assign wr_addr = AW'(wr_sel ? MAX_BEATS : 0) + AW'(wr_ptr);
   assign rd_addr = AW'(rd_sel ? MAX_BEATS : 0) + AW'(rd_ptr[7:0]);

   assign bus.target_tready    = armed && (nfull < 2'(NBUF));
   assign bus.initiator_tvalid = (state != FILL);
   assign bus.initiator_tdata  = out_data;

   always_comb begin
      state_nxt  = state;
      load_hdr   = 1'b0;
      load_word  = 1'b0;
      drain_done = 1'b0;
      case (state)
         FILL: begin
            if (nfull != 2'd0 || close_now) begin
               state_nxt = HEADER;
               load_hdr  = 1'b1;
            end
         end
         HEADER: begin
            if (out_hs) begin
               state_nxt = DRAIN;
               load_word = 1'b1;
            end
         end
         DRAIN: begin
            if (out_hs) begin
               if (rd_ptr == {1'b0, cur_beats} + 9'd1) begin
                  state_nxt  = FILL;
                  drain_done = 1'b1;
               end else begin
                  load_word = 1'b1;
               end
            end
         end
         default: state_nxt = FILL;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state     <= FILL;
         armed     <= 1'b0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         wr_sel    <= 1'b0;
         rd_sel    <= 1'b0;
         nfull     <= '0;
         cur_beats <= '0;
         out_data  <= '0;
      end else begin
         state <= state_nxt;
         armed <= 1'b1;
         if (in_hs)
            wr_ptr <= close_now ? 8'd0 : wr_ptr + 8'd1;
         nfull <= nfull + 2'(close_now) - 2'(drain_done);
         if (load_hdr) begin
            out_data  <= next_hdr;
            cur_beats <= next_hdr[23:16];
            rd_ptr    <= '0;
         end
         // Output register doubles as the RAM read register: the next word is fetched on each handshake.
         if (load_word) begin
            out_data <= mem[rd_addr];
            rd_ptr   <= rd_ptr + 9'd1;
         end
`ifdef STREAM_COMPRESSOR_PINGPONG_EN
         if (close_now)
            wr_sel <= ~wr_sel;
         if (drain_done)
            rd_sel <= ~rd_sel;
`endif
      end
   end

   always_ff @(posedge aclk) begin
      if (in_hs)
         mem[wr_addr] <= bus.target_tdata;
      if (in_hs && first_beat) begin
         seg_tid   <= bus.target_tid;
         seg_tdest <= bus.target_tdest;
      end
      if (close_now)
         hdr_buf[wr_sel] <= live_hdr;
   end
endmodule
